dispatch_unit: RTL and testbench
================================

// Module: dispatch_unit
// PURPOSE
//  Consumes the two head entries of the issue queue. Checks register hazards against a 32-entry scoreboard
//  and the dual-issue pairing rules. Returns issue_enable to the queue in the same cycle.
//  Registers the issued instructions into a two-slot dispatch stage that feeds execute.
// PARAMETERS
//  ENTRY_W   107    issue-queue entry width
//  NREG      32     architectural registers tracked by the scoreboard (r0 never busy)
//  TYPE_BR   4'd1   inst_type code for branch/jump
//  TYPE_MEM  4'd2   inst_type code for load/store (single LSU)
//  TYPE_MUL  4'd3   inst_type code for mul/div (single unit)
// PORTS
//  clk           in   1        clock
//  rst_          in   1        asynchronous, active-low reset
//  flush         in   1        pipeline flush from commit/branch resolve
//  inst0_in      in   ENTRY_W  queue head entry
//  inst1_in      in   ENTRY_W  queue head+1 entry
//  ex_allow_in   in   1        execute stage can accept a new pair this cycle
//  wb0_en        in   1        writeback port 0 retires a destination
//  wb0_addr      in   5        writeback port 0 destination register
//  wb1_en        in   1        writeback port 1 retires a destination
//  wb1_addr      in   5        writeback port 1 destination register
//  issue_enable  out  2        10 = pop two, 01 = pop one, 00 = pop none (combinational)
//  ds_inst0      out  ENTRY_W  dispatched slot 0 (registered)
//  ds_inst1      out  ENTRY_W  dispatched slot 1 (registered)
//  ds_valid      out  2        [0] slot0 valid, [1] slot1 valid (slot1 valid implies slot0 valid)
// BEHAVIOUR
//  Entry fields: [106:75] pc, [74:70] dst, [69:65] src0, [64:60] src1, [59:28] imme, [27:24] inst_type,
//   [23:18] meaning, [17:12] decode_valid ([0] dst used, [1] src0 used, [2] src1 used), [11:7] ptab,
//   [6:2] exe_code, [1] delot, [0] entry valid.
//  Reset: ds_valid=0, ds_inst0=ds_inst1=0, all scoreboard bits clear. issue_enable=00 while rst_ low.
//  hazard(x): any used src of x, or used dst of x with dst!=0, has its scoreboard bit set.
//   Bits being cleared by wb0/wb1 in the current cycle still count as busy (no bypass).
//  can0 = inst0.valid & !hazard(inst0) & ex_allow_in & !flush.
//  can1 = can0 & inst1.valid & !hazard(inst1) and all of the following:
//   - no RAW: inst1 does not use a src equal to inst0.dst (inst0 dst used, dst!=0);
//   - no WAW: inst0 and inst1 do not both use a nonzero dst that is the same register;
//   - not both TYPE_MEM, and not both TYPE_MUL;
//   - inst1 is not TYPE_BR (a branch in slot 1 is held so that it pairs with its delay slot next cycle).
//  issue_enable = can1 ? 10 : can0 ? 01 : 00. In-order: inst1 never issues alone.
//  Dispatch register (latency 1):
//   - when ex_allow_in=1: ds_inst0<=inst0_in, ds_inst1<=inst1_in,
//     ds_valid<={can1, can0};
//   - when ex_allow_in=0: ds_inst0, ds_inst1 and ds_valid hold.
//  Scoreboard, per cycle:
//   - clear wb0_addr if wb0_en, and clear wb1_addr if wb1_en;
//   - then set the dst of each issued instruction (dst used, dst!=0);
//   - set wins over a same-cycle clear of the same register;
//   - bit 0 is never set.
//  flush (synchronous, highest priority after reset):
//   - issue_enable forced to 00;
//   - next edge: ds_valid<=0 and all scoreboard bits cleared;
//   - writebacks in the flush cycle are ignored.
//  flush and ex_allow_in=0 together: flush wins, ds_valid clears.
//  Reset asserted mid-operation: all state returns to reset values asynchronously. No partial pair survives.
// TESTING
//  T1: independent ALU pair (dst r3/r4, srcs r1,r2), empty scoreboard -> issue_enable=10;
//      next cycle ds_valid=11 and sb[3]=sb[4]=1.
//  T2: inst1 src0=r3 = inst0 dst r3 -> issue_enable=01, ds_valid=01;
//      the following cycle inst1 at head stalls (00) until wb0_en with addr 3, then 01.
//  T3: both TYPE_MEM, no reg hazard -> 01; then inst1 is TYPE_BR with inst0 ALU -> 01;
//      then branch+delay-slot pair -> 10.
//  T4: wb0_addr=5 clears and an issuing inst with dst r5 in the same cycle -> sb[5]=1 afterwards;
//      an inst with dst r0 never sets sb[0].
//  T5: ex_allow_in=0 with valid pair -> issue_enable=00, ds outputs hold for 3 cycles,
//      then release -> 10.
//  T6: flush with ds_valid=11 and sb[7]=1 -> same cycle issue_enable=00; next cycle ds_valid=00,
//      scoreboard all zero; async rst_ pulse mid-stream -> all outputs 0.

Source files
------------

// File: rtl/dispatch_unit_if.sv
// Bundle between the issue queue / writeback / execute side and the dispatch unit.
interface dispatch_unit_if #(
  parameter int ENTRY_W = 107
);
  logic               flush;
  logic [ENTRY_W-1:0] inst0_in;
  logic [ENTRY_W-1:0] inst1_in;
  logic               ex_allow_in;
  logic               wb0_en;
  logic [4:0]         wb0_addr;
  logic               wb1_en;
  logic [4:0]         wb1_addr;
  logic [1:0]         issue_enable;
  logic [ENTRY_W-1:0] ds_inst0;
  logic [ENTRY_W-1:0] ds_inst1;
  logic [1:0]         ds_valid;

  modport master (
    output flush, inst0_in, inst1_in, ex_allow_in, wb0_en, wb0_addr, wb1_en, wb1_addr,
    input  issue_enable, ds_inst0, ds_inst1, ds_valid
  );

  modport slave (
    input  flush, inst0_in, inst1_in, ex_allow_in, wb0_en, wb0_addr, wb1_en, wb1_addr,
    output issue_enable, ds_inst0, ds_inst1, ds_valid
  );
endinterface

// File: rtl/dispatch_unit.sv
// Dual-issue dispatch: scoreboard hazard check, pairing rules, and a two-slot dispatch register.
module dispatch_unit #(
  parameter int         ENTRY_W  = 107,
  parameter int         NREG     = 32,
  parameter logic [3:0] TYPE_BR  = 4'd1,
  parameter logic [3:0] TYPE_MEM = 4'd2,
  parameter logic [3:0] TYPE_MUL = 4'd3
) (
  input logic           clk,
  input logic           rst_,
  dispatch_unit_if.slave bus
);

  logic [NREG-1:0] sb_reg;
  logic [NREG-1:0] sb_next;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;

  logic [4:0] dst0, src00, src01, dst1, src10, src11;
  logic [3:0] type0, type1;
  logic [2:0] used0, used1;
  logic       valid0, valid1;

  assign dst0   = bus.inst0_in[74:70];
  assign src00  = bus.inst0_in[69:65];
  assign src01  = bus.inst0_in[64:60];
  assign type0  = bus.inst0_in[27:24];
  assign used0  = bus.inst0_in[14:12];
  assign valid0 = bus.inst0_in[0];
  assign dst1   = bus.inst1_in[74:70];
  assign src10  = bus.inst1_in[69:65];
  assign src11  = bus.inst1_in[64:60];
  assign type1  = bus.inst1_in[27:24];
  assign used1  = bus.inst1_in[14:12];
  assign valid1 = bus.inst1_in[0];

  logic haz0, haz1, raw, waw, unit_conflict, can0, can1;

  always_comb begin
    haz0 = (used0[1] && sb_reg[src00]) || (used0[2] && sb_reg[src01]) ||
           (used0[0] && dst0 != 5'd0 && sb_reg[dst0]);
    haz1 = (used1[1] && sb_reg[src10]) || (used1[2] && sb_reg[src11]) ||
           (used1[0] && dst1 != 5'd0 && sb_reg[dst1]);
    raw  = used0[0] && dst0 != 5'd0 &&
           ((used1[1] && src10 == dst0) || (used1[2] && src11 == dst0));
    waw  = used0[0] && used1[0] && dst0 != 5'd0 && dst0 == dst1;
    unit_conflict = (type0 == TYPE_MEM && type1 == TYPE_MEM) ||
                    (type0 == TYPE_MUL && type1 == TYPE_MUL);
    // rst_ gating keeps the queue from popping while the block is held in reset.
    can0 = rst_ && valid0 && !haz0 && bus.ex_allow_in && !bus.flush;
    can1 = can0 && valid1 && !haz1 && !raw && !waw && !unit_conflict && type1 != TYPE_BR;
  end

  assign bus.issue_enable = can1 ? 2'b10 : (can0 ? 2'b01 : 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      assign clr_mask[gi] = (bus.wb0_en && bus.wb0_addr == 5'(gi)) ||
                            (bus.wb1_en && bus.wb1_addr == 5'(gi));
      if (gi == 0) begin : g_zero
        assign set_mask[gi] = 1'b0;
      end else begin : g_nz
        assign set_mask[gi] = (can0 && used0[0] && dst0 == 5'(gi)) ||
                              (can1 && used1[0] && dst1 == 5'(gi));
      end
    end
  endgenerate

  // Set is applied after clear so a same-cycle reissue of a retiring register stays busy.
  assign sb_next = bus.flush ? '0 : ((sb_reg & ~clr_mask) | set_mask);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sb_reg       <= '0;
      bus.ds_valid <= 2'b00;
      bus.ds_inst0 <= '0;
      bus.ds_inst1 <= '0;
    end else begin
      sb_reg <= sb_next;
      if (bus.ex_allow_in) begin
        bus.ds_inst0 <= bus.inst0_in;
        bus.ds_inst1 <= bus.inst1_in;
      end
      if (bus.flush)
        bus.ds_valid <= 2'b00;
      else if (bus.ex_allow_in)
        bus.ds_valid <= {can1, can0};
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: hazards, pairing rules, stall, flush and async reset.
module tb_dispatch_unit;
  localparam int W = 107;
  localparam logic [3:0] ALU = 4'd0, BR = 4'd1, MEM = 4'd2, MUL = 4'd3;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int total = 0;
  int bad = 0;

  dispatch_unit_if #(.ENTRY_W(W)) bus ();
  dispatch_unit dut (.clk(clk), .rst_(rst_), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(input logic [4:0] d, input logic [4:0] s0,
                                       input logic [4:0] s1, input logic [3:0] t,
                                       input logic [2:0] u, input logic v);
    logic [W-1:0] e;
    e = '0;
    e[106:75] = 32'h0000_1000;
    e[74:70] = d; e[69:65] = s0; e[64:60] = s1;
    e[27:24] = t; e[14:12] = u; e[0] = v;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst0_in = '0; bus.inst1_in = '0;
    bus.wb0_en = 1'b0; bus.wb1_en = 1'b0; bus.wb0_addr = 5'd0; bus.wb1_addr = 5'd0;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.ex_allow_in = 1'b1; idle_inputs();
    bus.inst0_in = ent(3, 1, 2, ALU, 3'b111, 1); bus.inst1_in = ent(4, 1, 2, ALU, 3'b111, 1);
    #1;
    total++; if (bus.issue_enable !== 2'b00) begin bad++; $display("FAIL rst_ie got=%b exp=00", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_valid !== 2'b00) begin bad++; $display("FAIL rst_dsv got=%b exp=00", bus.ds_valid); end
    total++; if (bus.ds_inst0 !== '0 || bus.ds_inst1 !== '0) begin bad++; $display("FAIL rst_dsinst got=%h/%h exp=0", bus.ds_inst0, bus.ds_inst1); end
    total++; if (dut.sb_reg !== 32'h0) begin bad++; $display("FAIL rst_sb got=%h exp=0", dut.sb_reg); end
    idle_inputs();
    rst_ = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_pair();
    logic [W-1:0] a0, a1;
    a0 = ent(3, 1, 2, ALU, 3'b111, 1); a1 = ent(4, 1, 2, ALU, 3'b111, 1);
    bus.inst0_in = a0; bus.inst1_in = a1;
    #1;
    total++; if (bus.issue_enable !== 2'b10) begin bad++; $display("FAIL t1_ie got=%b exp=10", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_valid !== 2'b11) begin bad++; $display("FAIL t1_dsv got=%b exp=11", bus.ds_valid); end
    total++; if (bus.ds_inst0 !== a0 || bus.ds_inst1 !== a1) begin bad++; $display("FAIL t1_dsinst got=%h/%h", bus.ds_inst0, bus.ds_inst1); end
    total++; if (dut.sb_reg !== 32'h18) begin bad++; $display("FAIL t1_sb got=%h exp=18", dut.sb_reg); end
    idle_inputs(); bus.wb0_en = 1'b1; bus.wb0_addr = 5'd3; bus.wb1_en = 1'b1; bus.wb1_addr = 5'd4;
    cyc();
    idle_inputs();
    total++; if (dut.sb_reg !== 32'h0) begin bad++; $display("FAIL t1_wbclr got=%h exp=0", dut.sb_reg); end
    $display("pair: ie=10 ds_valid=11 then writeback clear");
  endtask

  task automatic test_raw();
    logic [W-1:0] b1;
    b1 = ent(6, 3, 2, ALU, 3'b111, 1);
    bus.inst0_in = ent(3, 1, 2, ALU, 3'b111, 1); bus.inst1_in = b1;
    #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t2_ie got=%b exp=01", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_valid !== 2'b01) begin bad++; $display("FAIL t2_dsv got=%b exp=01", bus.ds_valid); end
    total++; if (dut.sb_reg !== 32'h8) begin bad++; $display("FAIL t2_sb got=%h exp=8", dut.sb_reg); end
    bus.inst0_in = b1; bus.inst1_in = '0;
    #1;
    total++; if (bus.issue_enable !== 2'b00) begin bad++; $display("FAIL t2_stall got=%b exp=00", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_valid !== 2'b00) begin bad++; $display("FAIL t2_stall_dsv got=%b exp=00", bus.ds_valid); end
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd3;
    #1;
    total++; if (bus.issue_enable !== 2'b00) begin bad++; $display("FAIL t2_nobypass got=%b exp=00", bus.issue_enable); end
    cyc();
    bus.wb0_en = 1'b0;
    #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t2_release got=%b exp=01", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_valid !== 2'b01 || bus.ds_inst0 !== b1) begin bad++; $display("FAIL t2_dispatch got=%b/%h", bus.ds_valid, bus.ds_inst0); end
    total++; if (dut.sb_reg !== 32'h40) begin bad++; $display("FAIL t2_sb6 got=%h exp=40", dut.sb_reg); end
    idle_inputs(); bus.wb0_en = 1'b1; bus.wb0_addr = 5'd6;
    cyc();
    idle_inputs();
    $display("raw: split issue, stall, release after writeback");
  endtask

  task automatic test_pairing_rules();
    bus.inst0_in = ent(0, 1, 2, MEM, 3'b110, 1); bus.inst1_in = ent(0, 1, 2, MEM, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t3_mem got=%b exp=01", bus.issue_enable); end
    bus.inst0_in = ent(0, 1, 2, MUL, 3'b110, 1); bus.inst1_in = ent(0, 1, 2, MUL, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t3_mul got=%b exp=01", bus.issue_enable); end
    bus.inst0_in = ent(0, 1, 2, MEM, 3'b110, 1); bus.inst1_in = ent(0, 1, 2, MUL, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b10) begin bad++; $display("FAIL t3_memmul got=%b exp=10", bus.issue_enable); end
    bus.inst0_in = ent(0, 1, 2, ALU, 3'b110, 1); bus.inst1_in = ent(0, 1, 2, BR, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t3_br1 got=%b exp=01", bus.issue_enable); end
    bus.inst0_in = ent(0, 1, 2, BR, 3'b110, 1); bus.inst1_in = ent(0, 1, 2, ALU, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b10) begin bad++; $display("FAIL t3_brds got=%b exp=10", bus.issue_enable); end
    bus.inst0_in = ent(9, 1, 2, ALU, 3'b111, 1); bus.inst1_in = ent(0, 1, 9, ALU, 3'b110, 1); #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t3_raw_src1 got=%b exp=01", bus.issue_enable); end
    bus.inst0_in = ent(10, 1, 2, ALU, 3'b001, 1); bus.inst1_in = ent(10, 1, 2, ALU, 3'b001, 1); #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t3_waw got=%b exp=01", bus.issue_enable); end
    cyc();
    total++; if (dut.sb_reg !== 32'h400) begin bad++; $display("FAIL t3_sb got=%h exp=400", dut.sb_reg); end
    idle_inputs(); bus.wb1_en = 1'b1; bus.wb1_addr = 5'd10;
    cyc();
    idle_inputs();
    total++; if (dut.sb_reg !== 32'h0) begin bad++; $display("FAIL t3_wb1clr got=%h exp=0", dut.sb_reg); end
    $display("pairing: mem/mul/branch/raw/waw rules");
  endtask

  task automatic test_set_wins();
    bus.inst0_in = ent(5, 1, 2, ALU, 3'b111, 1); bus.wb0_en = 1'b1; bus.wb0_addr = 5'd5; #1;
    total++; if (bus.issue_enable !== 2'b01) begin bad++; $display("FAIL t4_ie got=%b exp=01", bus.issue_enable); end
    cyc();
    total++; if (dut.sb_reg !== 32'h20) begin bad++; $display("FAIL t4_setwins got=%h exp=20", dut.sb_reg); end
    idle_inputs();
    bus.inst0_in = ent(0, 1, 2, ALU, 3'b001, 1); bus.inst1_in = ent(0, 1, 2, ALU, 3'b001, 1); #1;
    total++; if (bus.issue_enable !== 2'b10) begin bad++; $display("FAIL t4_r0pair got=%b exp=10", bus.issue_enable); end
    cyc();
    total++; if (dut.sb_reg !== 32'h20) begin bad++; $display("FAIL t4_r0 got=%h exp=20", dut.sb_reg); end
    idle_inputs(); bus.wb1_en = 1'b1; bus.wb1_addr = 5'd5;
    cyc();
    idle_inputs();
    $display("set_wins: sb[5] kept, sb[0] never set");
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] a0, a1, b0, b1;
    a0 = ent(11, 1, 2, ALU, 3'b111, 1); a1 = ent(12, 1, 2, ALU, 3'b111, 1);
    b0 = ent(13, 1, 2, ALU, 3'b111, 1); b1 = ent(14, 1, 2, ALU, 3'b111, 1);
    bus.inst0_in = a0; bus.inst1_in = a1;
    cyc();
    total++; if (bus.ds_valid !== 2'b11) begin bad++; $display("FAIL t5_a_dsv got=%b exp=11", bus.ds_valid); end
    bus.ex_allow_in = 1'b0; bus.inst0_in = b0; bus.inst1_in = b1; #1;
    total++; if (bus.issue_enable !== 2'b00) begin bad++; $display("FAIL t5_ie got=%b exp=00", bus.issue_enable); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (bus.ds_valid !== 2'b11 || bus.ds_inst0 !== a0 || bus.ds_inst1 !== a1 || dut.sb_reg !== 32'h1800) begin
        bad++; $display("FAIL t5_hold%0d got=%b/%h sb=%h", i, bus.ds_valid, bus.ds_inst0, dut.sb_reg);
      end
    end
    bus.ex_allow_in = 1'b1; #1;
    total++; if (bus.issue_enable !== 2'b10) begin bad++; $display("FAIL t5_rel got=%b exp=10", bus.issue_enable); end
    cyc();
    total++; if (bus.ds_inst0 !== b0 || bus.ds_inst1 !== b1 || bus.ds_valid !== 2'b11) begin bad++; $display("FAIL t5_b got=%b/%h", bus.ds_valid, bus.ds_inst0); end
    total++; if (dut.sb_reg !== 32'h7800) begin bad++; $display("FAIL t5_sb got=%h exp=7800", dut.sb_reg); end
    $display("stall: held 3 cycles then pair issued");
  endtask

  task automatic test_flush_reset();
    bus.flush = 1'b1; bus.inst0_in = ent(15, 1, 2, ALU, 3'b111, 1); bus.inst1_in = ent(16, 1, 2, ALU, 3'b111, 1);
    bus.wb0_en = 1'b1; bus.wb0_addr = 5'd11; #1;
    total++; if (bus.issue_enable !== 2'b00) begin bad++; $display("FAIL t6_ie got=%b exp=00", bus.issue_enable); end
    cyc();
    bus.flush = 1'b0; bus.wb0_en = 1'b0;
    total++; if (bus.ds_valid !== 2'b00) begin bad++; $display("FAIL t6_dsv got=%b exp=00", bus.ds_valid); end
    total++; if (dut.sb_reg !== 32'h0) begin bad++; $display("FAIL t6_sb got=%h exp=0", dut.sb_reg); end
    cyc();
    total++; if (bus.ds_valid !== 2'b11) begin bad++; $display("FAIL t6_reissue got=%b exp=11", bus.ds_valid); end
    bus.flush = 1'b1; bus.ex_allow_in = 1'b0;
    cyc();
    bus.flush = 1'b0; bus.ex_allow_in = 1'b1;
    total++; if (bus.ds_valid !== 2'b00 || dut.sb_reg !== 32'h0) begin bad++; $display("FAIL t6_flushstall got=%b sb=%h", bus.ds_valid, dut.sb_reg); end
    cyc();
    #3 rst_ = 1'b0;
    #1;
    total++;
    if (bus.ds_valid !== 2'b00 || bus.ds_inst0 !== '0 || bus.ds_inst1 !== '0 || dut.sb_reg !== 32'h0 || bus.issue_enable !== 2'b00) begin
      bad++; $display("FAIL t6_async got=%b/%h/%h sb=%h ie=%b", bus.ds_valid, bus.ds_inst0, bus.ds_inst1, dut.sb_reg, bus.issue_enable);
    end
    idle_inputs();
    rst_ = 1'b1;
    cyc();
    total++; if (bus.ds_valid !== 2'b00) begin bad++; $display("FAIL t6_after got=%b exp=00", bus.ds_valid); end
    $display("flush_reset: flush clears state, async reset clears outputs");
  endtask

  initial begin
    test_reset();
    test_pair();
    test_raw();
    test_pairing_rules();
    test_set_wins();
    test_back_to_back_stall();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
